// File: rtl/eth_tx_framer.sv
// eth_tx_framer
//
// Builds an Ethernet frame from payload bytes held in an upstream byte FIFO.
// Frame order: 7 x 0x55 preamble, 0xD5 SFD, len payload bytes, zero pad up to
// MIN_LEN, optional 4-byte FCS (LSB first), then IFG_CYCLES idle cycles.
//
// Optional feature macro: TX_FCS_EN
//   defined   -> reflected CRC-32 over payload+pad, FCS appended, tx_last on
//                the 4th FCS byte.
//   undefined -> no CRC logic, tx_last on the final payload/pad byte.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   start, len     frame request and payload length (sampled only in IDLE)
//   busy           frame or inter-frame gap in progress
//   fifo_rd_en     read strobe to FIFO; fifo_dout valid one cycle later
//   fifo_dout      FIFO read data
//   fifo_empty     FIFO empty flag
//   tx_valid       tx_data / tx_last valid (registered, held until tx_ready)
//   tx_data        frame byte
//   tx_last        marks the final byte of the frame
//   tx_ready       downstream accepts the byte on tx_valid & tx_ready
module eth_tx_framer #(
  parameter int MIN_LEN    = 60,
  parameter int IFG_CYCLES = 12,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 busy,
  output logic                 fifo_rd_en,
  input  logic [7:0]           fifo_dout,
  input  logic                 fifo_empty,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_last,
  input  logic                 tx_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_PAYLOAD, S_PAD, S_FCS, S_IFG
  } state_t;

  localparam logic [LEN_WIDTH-1:0] MIN_LEN_W  = LEN_WIDTH'(MIN_LEN);
  localparam logic [LEN_WIDTH-1:0] MIN_LEN_M1 = LEN_WIDTH'(MIN_LEN - 1);
  localparam logic [LEN_WIDTH-1:0] PRE_LAST   = LEN_WIDTH'(6);
  localparam logic [15:0]          IFG_LAST   = 16'(IFG_CYCLES - 1);

  state_t               state, state_nxt;
  logic [LEN_WIDTH-1:0] cnt, cnt_nxt;
  logic [15:0]          ifg_cnt, ifg_nxt;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] len_m1;
  logic [LEN_WIDTH-1:0] req_cnt;

  // Two-entry prefetch buffer; buf0 is the head.
  logic [7:0]           buf0, buf1;
  logic [1:0]           buf_cnt;
  logic                 inflight;
  logic                 head_vld;
  logic [7:0]           head_byte;
  logic                 pop;

  logic                 accept;
  logic                 load;
  logic                 out_we, out_valid, out_last;
  logic [7:0]           out_data;

`ifdef TX_FCS_EN
  logic [31:0]          crc;
  logic [31:0]          fcs;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  assign fcs = ~crc;
`endif

  assign busy      = (state != S_IDLE);
  assign accept    = (state == S_IDLE) && start;
  // Output register can take a new byte when empty or being accepted now.
  assign load      = !tx_valid || tx_ready;
  assign len_m1    = len_q - LEN_WIDTH'(1);
  // A byte arriving from the FIFO this cycle can be forwarded directly when
  // the buffer is empty, which keeps the payload at one byte per cycle.
  assign head_vld  = (buf_cnt != 2'd0) || inflight;
  assign head_byte = (buf_cnt != 2'd0) ? buf0 : fifo_dout;

  assign fifo_rd_en = !rst && !fifo_empty &&
                      (state == S_PREAMBLE || state == S_SFD || state == S_PAYLOAD) &&
                      ((buf_cnt + 2'(inflight)) < 2'd2) &&
                      (req_cnt < len_q);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ifg_nxt   = ifg_cnt;
    out_we    = 1'b0;
    out_valid = 1'b0;
    out_data  = tx_data;
    out_last  = 1'b0;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          out_we    = 1'b1;
          out_valid = 1'b1;
          out_data  = 8'h55;
          cnt_nxt   = LEN_WIDTH'(1);
          state_nxt = S_PREAMBLE;
        end
      end
      S_PREAMBLE: begin
        if (load) begin
          out_we    = 1'b1;
          out_valid = 1'b1;
          out_data  = 8'h55;
          cnt_nxt   = cnt + LEN_WIDTH'(1);
          if (cnt == PRE_LAST) state_nxt = S_SFD;
        end
      end
      S_SFD: begin
        if (load) begin
          out_we    = 1'b1;
          out_valid = 1'b1;
          out_data  = 8'hD5;
          cnt_nxt   = '0;
          if (len_q != '0) state_nxt = S_PAYLOAD;
          else if (MIN_LEN > 0) state_nxt = S_PAD;
          else begin
`ifdef TX_FCS_EN
            state_nxt = S_FCS;
`else
            out_last  = 1'b1;
            state_nxt = S_IFG;
`endif
          end
        end
      end
      S_PAYLOAD: begin
        if (load) begin
          out_we = 1'b1;
          if (head_vld) begin
            out_valid = 1'b1;
            out_data  = head_byte;
            pop       = 1'b1;
            cnt_nxt   = cnt + LEN_WIDTH'(1);
            if (cnt == len_m1) begin
              if (len_q < MIN_LEN_W) state_nxt = S_PAD;
              else begin
`ifdef TX_FCS_EN
                cnt_nxt   = '0;
                state_nxt = S_FCS;
`else
                out_last  = 1'b1;
                state_nxt = S_IFG;
`endif
              end
            end
          end
        end
      end
      S_PAD: begin
        if (load) begin
          out_we    = 1'b1;
          out_valid = 1'b1;
          out_data  = 8'h00;
          cnt_nxt   = cnt + LEN_WIDTH'(1);
          if (cnt == MIN_LEN_M1) begin
`ifdef TX_FCS_EN
            cnt_nxt   = '0;
            state_nxt = S_FCS;
`else
            out_last  = 1'b1;
            state_nxt = S_IFG;
`endif
          end
        end
      end
`ifdef TX_FCS_EN
      S_FCS: begin
        if (load) begin
          out_we    = 1'b1;
          out_valid = 1'b1;
          case (cnt[1:0])
            2'd0:    out_data = fcs[7:0];
            2'd1:    out_data = fcs[15:8];
            2'd2:    out_data = fcs[23:16];
            default: out_data = fcs[31:24];
          endcase
          cnt_nxt = cnt + LEN_WIDTH'(1);
          if (cnt[1:0] == 2'd3) begin
            out_last  = 1'b1;
            state_nxt = S_IFG;
          end
        end
      end
`endif
      S_IFG: begin
        // The gap starts counting only once the final byte has been taken.
        if (tx_valid) begin
          if (tx_ready) begin
            out_we  = 1'b1;
            ifg_nxt = '0;
          end
        end else begin
          ifg_nxt = ifg_cnt + 16'd1;
          if (ifg_cnt >= IFG_LAST) state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control and output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      ifg_cnt  <= '0;
      len_q    <= '0;
      req_cnt  <= '0;
      buf_cnt  <= 2'd0;
      inflight <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      tx_last  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ifg_cnt  <= ifg_nxt;
      inflight <= fifo_rd_en;
      buf_cnt  <= buf_cnt + 2'(inflight) - 2'(pop);
      if (accept) begin
        len_q   <= len;
        req_cnt <= '0;
      end else if (fifo_rd_en) begin
        req_cnt <= req_cnt + LEN_WIDTH'(1);
      end
      if (out_we) begin
        tx_valid <= out_valid;
        tx_data  <= out_data;
        tx_last  <= out_last;
      end
    end
  end

  // Prefetch buffer data stage
  always_ff @(posedge clk) begin
    case ({inflight, pop})
      2'b11: begin
        if (buf_cnt == 2'd1) begin
          buf0 <= fifo_dout;
        end else if (buf_cnt == 2'd2) begin
          buf0 <= buf1;
          buf1 <= fifo_dout;
        end
      end
      2'b01: buf0 <= buf1;
      2'b10: begin
        if (buf_cnt == 2'd0) buf0 <= fifo_dout;
        else                 buf1 <= fifo_dout;
      end
      default: ;
    endcase
  end

`ifdef TX_FCS_EN
  // CRC stage
  always_ff @(posedge clk) begin
    if (accept) begin
      crc <= 32'hFFFF_FFFF;
    end else if (out_we && out_valid && (state == S_PAYLOAD || state == S_PAD)) begin
      crc <= crc32_byte(crc, out_data);
    end
  end
`endif

endmodule

// File: tb/tb_eth_tx_framer.sv
module tb_eth_tx_framer;
  localparam int MIN_LEN    = 9;
  localparam int IFG_CYCLES = 12;
  localparam int LEN_WIDTH  = 11;
`ifdef TX_FCS_EN
  localparam int FCS_BYTES = 4;
`else
  localparam int FCS_BYTES = 0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [LEN_WIDTH-1:0] len = '0;
  logic                 busy;
  logic                 fifo_rd_en;
  logic [7:0]           fifo_dout = 8'h00;
  logic                 fifo_empty;
  logic                 tx_valid;
  logic [7:0]           tx_data;
  logic                 tx_last;
  logic                 tx_ready = 1'b1;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  eth_tx_framer #(.MIN_LEN(MIN_LEN), .IFG_CYCLES(IFG_CYCLES), .LEN_WIDTH(LEN_WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready)
  );

  // FIFO model with registered read port
  logic [7:0] fmem [0:255];
  int fwp = 0;
  int frp = 0;
  int nreads = 0;
  int underflows = 0;
  assign fifo_empty = (fwp == frp);
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fwp == frp) underflows <= underflows + 1;
      fifo_dout <= fmem[frp % 256];
      frp       <= frp + 1;
      nreads    <= nreads + 1;
    end
  end

  // Capture of accepted bytes and hold-stability monitor
  logic [7:0] cap_d [$];
  logic       cap_l [$];
  int         hold_err = 0;
  logic       pend = 1'b0;
  logic [8:0] pend_v = '0;
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      cap_d.push_back(tx_data);
      cap_l.push_back(tx_last);
    end
    if (!rst && pend && (!tx_valid || ({tx_data, tx_last} != pend_v))) hold_err <= hold_err + 1;
    pend   <= !rst && tx_valid && !tx_ready;
    pend_v <= {tx_data, tx_last};
  end

  // Expected frame model
  logic [7:0] pl [0:127];
  logic [7:0] exp_d [$];

  function automatic logic [31:0] crc_model(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    logic fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ d[i];
      c  = c >> 1;
      if (fb) c = c ^ 32'hEDB88320;
    end
    return c;
  endfunction

  task automatic build_exp(input int n);
    logic [31:0] c;
    logic [7:0]  b;
    int body;
    exp_d.delete();
    c = 32'hFFFFFFFF;
    body = (n > MIN_LEN) ? n : MIN_LEN;
    for (int i = 0; i < 7; i++) exp_d.push_back(8'h55);
    exp_d.push_back(8'hD5);
    for (int i = 0; i < body; i++) begin
      b = (i < n) ? pl[i] : 8'h00;
      exp_d.push_back(b);
      c = crc_model(c, b);
    end
`ifdef TX_FCS_EN
    c = ~c;
    for (int i = 0; i < 4; i++) exp_d.push_back(c[8*i +: 8]);
`endif
  endtask

  function automatic int first_diff();
    for (int i = 0; i < exp_d.size() && i < cap_d.size(); i++)
      if (cap_d[i] !== exp_d[i]) return i;
    if (cap_d.size() != exp_d.size())
      return (cap_d.size() < exp_d.size()) ? cap_d.size() : exp_d.size();
    return -1;
  endfunction

  function automatic int last_idx();
    int idx;
    idx = -1;
    for (int i = 0; i < cap_l.size(); i++)
      if (cap_l[i]) begin
        if (idx != -1) return -2;
        idx = i;
      end
    return idx;
  endfunction

  task automatic push_fifo(input int from, input int n);
    for (int i = from; i < from + n; i++) begin
      fmem[fwp % 256] = pl[i];
      fwp = fwp + 1;
    end
  endtask

  // Stimulus drivers
  int   g_cycles;
  int   g_vcnt;
  logic g_done;
  logic g_first_ok;
  int   g_ifg;

  task automatic collect(input int rmode, input int refill_at, input int refill_n, input int ign_at);
    int cyc;
    cyc = 0;
    g_done = 1'b0; g_vcnt = 0; g_first_ok = 1'b0; g_cycles = -1;
    tx_ready = 1'b1;
    while (!g_done && cyc < 3000) begin
      @(negedge clk);
      if (cyc == 0) g_first_ok = busy && tx_valid && (tx_data == 8'h55);
      if (tx_valid) g_vcnt++;
      if (tx_valid && tx_ready && tx_last) begin
        g_done = 1'b1;
        g_cycles = cyc;
      end
      @(posedge clk); #1;
      cyc++;
      start = (cyc == ign_at);
      if (cyc == ign_at) len = LEN_WIDTH'(3);
      if (cyc == refill_at) push_fifo(3, refill_n);
      tx_ready = (rmode == 0) ? 1'b1 : !cyc[0];
    end
    start = 1'b0;
    tx_ready = 1'b1;
  endtask

  task automatic send(input int n, input int rmode, input int refill_at, input int refill_n, input int ign_at);
    cap_d.delete();
    cap_l.delete();
    start = 1'b1;
    len = LEN_WIDTH'(n);
    @(posedge clk); #1;
    start = 1'b0;
    collect(rmode, refill_at, refill_n, ign_at);
  endtask

  task automatic wait_ifg(input int pulse_at);
    int n;
    n = 0;
    g_ifg = 0;
    while (n < 200) begin
      @(negedge clk);
      start = 1'b0;
      if (!busy) break;
      if (!tx_valid) g_ifg++;
      if (g_ifg == pulse_at) begin
        start = 1'b1;
        len = LEN_WIDTH'(2);
      end
      n++;
    end
  endtask

  // Tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b, expected 0", busy);
    else passed++;
    total++;
    if ({tx_valid, tx_last, fifo_rd_en} !== 3'b000)
      $display("FAIL reset_ctrl: got valid/last/rd_en %b, expected 000", {tx_valid, tx_last, fifo_rd_en});
    else passed++;
    total++;
    if (tx_data !== 8'h00) $display("FAIL reset_data: got %h, expected 00", tx_data);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_check_vector();
    int r0, tot, d;
    logic [31:0] fcs_got;
    for (int i = 0; i < 9; i++) pl[i] = 8'h31 + 8'(i);
    push_fifo(0, 9);
    r0 = nreads;
    build_exp(9);
    tot = 8 + 9 + FCS_BYTES;
    send(9, 0, -1, 0, -1);
    total++;
    if (g_first_ok !== 1'b1) $display("FAIL cv_first_byte: got first-cycle ok=%b, expected 1", g_first_ok);
    else passed++;
    total++;
    if (g_done !== 1'b1) $display("FAIL cv_timeout: got done=%b, expected 1", g_done);
    else passed++;
    d = first_diff();
    total++;
    if (d !== -1) $display("FAIL cv_bytes: got mismatch at index %0d (size %0d), expected none (size %0d)", d, cap_d.size(), tot);
    else passed++;
    total++;
    if (last_idx() !== tot - 1) $display("FAIL cv_last: got tx_last at %0d, expected %0d", last_idx(), tot - 1);
    else passed++;
    total++;
    if (g_vcnt !== tot || g_cycles + 1 !== tot)
      $display("FAIL cv_throughput: got %0d valid in %0d cycles, expected %0d in %0d", g_vcnt, g_cycles + 1, tot, tot);
    else passed++;
`ifdef TX_FCS_EN
    fcs_got = (cap_d.size() >= 21) ? {cap_d[20], cap_d[19], cap_d[18], cap_d[17]} : 32'h0;
    total++;
    if (fcs_got !== 32'hCBF43926) $display("FAIL cv_fcs: got %h, expected cbf43926", fcs_got);
    else passed++;
`else
    fcs_got = (cap_d.size() >= 17) ? {24'h0, cap_d[16]} : 32'h0;
    total++;
    if (fcs_got !== 32'h39) $display("FAIL cv_final_byte: got %h, expected 39", fcs_got);
    else passed++;
`endif
    total++;
    if (nreads - r0 !== 9) $display("FAIL cv_reads: got %0d, expected 9", nreads - r0);
    else passed++;
    wait_ifg(-1);
    total++;
    if (g_ifg !== IFG_CYCLES || busy !== 1'b0)
      $display("FAIL cv_ifg: got %0d idle busy cycles (busy=%b), expected %0d", g_ifg, busy, IFG_CYCLES);
    else passed++;
  endtask

  task automatic test_pad_and_restart();
    int r0, tot, d;
    pl[0] = 8'hAB;
    push_fifo(0, 1);
    r0 = nreads;
    build_exp(1);
    tot = 8 + MIN_LEN + FCS_BYTES;
    send(1, 0, -1, 0, -1);
    d = first_diff();
    total++;
    if (g_done !== 1'b1 || d !== -1) $display("FAIL pad_bytes: got done=%b mismatch at %0d, expected done with none", g_done, d);
    else passed++;
    total++;
    if (last_idx() !== tot - 1) $display("FAIL pad_last: got tx_last at %0d, expected %0d", last_idx(), tot - 1);
    else passed++;
    total++;
    if (nreads - r0 !== 1) $display("FAIL pad_reads: got %0d, expected 1", nreads - r0);
    else passed++;
    wait_ifg(-1);
    total++;
    if (g_ifg !== IFG_CYCLES || busy !== 1'b0)
      $display("FAIL pad_ifg: got %0d idle busy cycles, expected %0d", g_ifg, IFG_CYCLES);
    else passed++;
    // start issued on the very cycle busy is first low
    r0 = nreads;
    build_exp(0);
    send(0, 0, -1, 0, -1);
    total++;
    if (g_first_ok !== 1'b1) $display("FAIL restart_accept: got first-cycle ok=%b, expected 1", g_first_ok);
    else passed++;
    d = first_diff();
    total++;
    if (g_done !== 1'b1 || d !== -1) $display("FAIL len0_bytes: got done=%b mismatch at %0d, expected none", g_done, d);
    else passed++;
    total++;
    if (nreads - r0 !== 0) $display("FAIL len0_reads: got %0d, expected 0", nreads - r0);
    else passed++;
    wait_ifg(-1);
  endtask

  task automatic test_backpressure();
    int h0, tot, d;
    for (int i = 0; i < 64; i++) pl[i] = 8'(i * 7 + 3);
    push_fifo(0, 64);
    h0 = hold_err;
    build_exp(64);
    tot = 8 + 64 + FCS_BYTES;
    send(64, 1, -1, 0, -1);
    d = first_diff();
    total++;
    if (g_done !== 1'b1 || d !== -1) $display("FAIL bp_bytes: got done=%b mismatch at %0d, expected none", g_done, d);
    else passed++;
    total++;
    if (hold_err - h0 !== 0) $display("FAIL bp_hold: got %0d unstable holds, expected 0", hold_err - h0);
    else passed++;
    total++;
    if (last_idx() !== tot - 1) $display("FAIL bp_last: got tx_last at %0d, expected %0d", last_idx(), tot - 1);
    else passed++;
    wait_ifg(-1);
  endtask

  task automatic test_fifo_gap();
    int r0, u0, tot, d;
    for (int i = 0; i < 10; i++) pl[i] = 8'hC0 + 8'(i);
    push_fifo(0, 3);
    r0 = nreads;
    u0 = underflows;
    build_exp(10);
    tot = 8 + 10 + FCS_BYTES;
    send(10, 0, 20, 7, -1);
    d = first_diff();
    total++;
    if (g_done !== 1'b1 || d !== -1) $display("FAIL gap_bytes: got done=%b mismatch at %0d, expected none", g_done, d);
    else passed++;
    total++;
    if (nreads - r0 !== 10) $display("FAIL gap_reads: got %0d, expected 10", nreads - r0);
    else passed++;
    total++;
    if (g_vcnt !== tot || (g_cycles + 1 - g_vcnt) < 5)
      $display("FAIL gap_valid: got %0d valid, %0d idle cycles, expected %0d valid and at least 5 idle", g_vcnt, g_cycles + 1 - g_vcnt, tot);
    else passed++;
    total++;
    if (underflows - u0 !== 0) $display("FAIL gap_underflow: got %0d reads while empty, expected 0", underflows - u0);
    else passed++;
    wait_ifg(-1);
  endtask

  task automatic test_reset_mid();
    int hs, n, r0, d;
    logic [7:0] seen;
    for (int i = 0; i < 10; i++) pl[i] = 8'h10 + 8'(i);
    push_fifo(0, 10);
    cap_d.delete();
    cap_l.delete();
    start = 1'b1;
    len = LEN_WIDTH'(10);
    @(posedge clk); #1;
    start = 1'b0;
    hs = 0; n = 0; seen = 8'h00;
    while (hs < 13 && n < 200) begin
      @(negedge clk);
      if (tx_valid && tx_ready) begin
        hs++;
        seen = tx_data;
      end
      n++;
    end
    rst = 1'b1;
    total++;
    if (seen !== 8'h14) $display("FAIL rstmid_point: got byte %h at reset point, expected 14", seen);
    else passed++;
    @(negedge clk);
    total++;
    if ({busy, tx_valid, tx_last, fifo_rd_en} !== 4'b0000)
      $display("FAIL rstmid_ctrl: got busy/valid/last/rd_en %b, expected 0000", {busy, tx_valid, tx_last, fifo_rd_en});
    else passed++;
    total++;
    if (tx_data !== 8'h00) $display("FAIL rstmid_data: got %h, expected 00", tx_data);
    else passed++;
    total++;
    if (last_idx() !== -1) $display("FAIL rstmid_nolast: got tx_last at %0d, expected none", last_idx());
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    fwp = frp;
    pl[0] = 8'hA5;
    pl[1] = 8'h5A;
    push_fifo(0, 2);
    r0 = nreads;
    build_exp(2);
    send(2, 0, -1, 0, -1);
    d = first_diff();
    total++;
    if (g_done !== 1'b1 || d !== -1) $display("FAIL rstmid_fresh: got done=%b mismatch at %0d, expected none", g_done, d);
    else passed++;
    total++;
    if (nreads - r0 !== 2) $display("FAIL rstmid_reads: got %0d, expected 2", nreads - r0);
    else passed++;
    wait_ifg(-1);
  endtask

  task automatic test_start_ignored();
    int r0, d, bad;
    for (int i = 0; i < 15; i++) pl[i] = 8'h60 + 8'(i);
    push_fifo(0, 15);
    r0 = nreads;
    build_exp(12);
    send(12, 0, -1, 0, 12);
    d = first_diff();
    total++;
    if (g_done !== 1'b1 || d !== -1) $display("FAIL ign_bytes: got done=%b mismatch at %0d, expected none", g_done, d);
    else passed++;
    wait_ifg(5);
    total++;
    if (g_ifg !== IFG_CYCLES) $display("FAIL ign_ifg: got %0d idle busy cycles, expected %0d", g_ifg, IFG_CYCLES);
    else passed++;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy || tx_valid) bad++;
    end
    total++;
    if (bad !== 0) $display("FAIL ign_second_frame: got %0d busy/valid cycles after gap, expected 0", bad);
    else passed++;
    total++;
    if (nreads - r0 !== 12) $display("FAIL ign_reads: got %0d, expected 12", nreads - r0);
    else passed++;
    fwp = frp;
  endtask

  initial begin
    test_reset();
    test_check_vector();
    test_pad_and_restart();
    test_backpressure();
    test_fifo_gap();
    test_reset_mid();
    test_start_ignored();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no completion, expected summary before time limit");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/eth_tx_framer.md
# eth_tx_framer

Transmit framer that drains payload bytes from the byte-wide `fifo` and emits a complete Ethernet frame as a byte stream toward the PHY serializer. It generates the preamble and SFD, pads short payloads, appends the CRC-32 FCS, and enforces the inter-frame gap. It sits directly downstream of the TX payload `fifo`, whose registered read port it drives.

## Interface
- `MIN_LEN`, 60: minimum payload+pad byte count; shorter payloads are zero-padded up to this count.
- `IFG_CYCLES`, 12: idle cycles after the last byte before the next frame may start.
- `LEN_WIDTH`, 11: width of `len`.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  single-cycle frame request; accepted only when `busy`=0.
- `len`  in  LEN_WIDTH  payload byte count, captured when `start` is accepted; 0 is legal (pad only).
- `busy`  out  1  frame in progress or IFG running.
- `fifo_rd_en`  out  1  read strobe to the FIFO.
- `fifo_dout`  in  8  FIFO data, valid the cycle after `fifo_rd_en`.
- `fifo_empty`  in  1  FIFO empty flag.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_data`  out  8  frame byte.
- `tx_last`  out  1  qualifies the final byte of the frame.
- `tx_ready`  in  1  downstream accepts the byte when `tx_valid`&`tx_ready`.

## Operation
- States: IDLE → PREAMBLE → SFD → PAYLOAD → PAD → FCS → IFG → IDLE.
- IDLE: on `start`, capture `len`, clear counters, set CRC to 0xFFFFFFFF, go to PREAMBLE.
- PREAMBLE: 7 bytes of 0x55. SFD: 1 byte of 0xD5.
- PAYLOAD: exactly `len` bytes taken from the FIFO in order. Skipped when `len`=0.
- PAD: `MIN_LEN - len` bytes of 0x00 when `len` < `MIN_LEN`; skipped otherwise.
- FCS: 4 bytes carrying `~crc`, least-significant byte first.
- IFG: `tx_valid`=0 for `IFG_CYCLES` cycles, then IDLE.
- CRC: reflected CRC-32, polynomial 0x04C11DB7, computed over payload and pad bytes only. It is updated on each accepted byte.
- Byte counters advance only on handshake (`tx_valid`&`tx_ready`).
- FIFO prefetch: a 2-entry holding buffer. `fifo_rd_en`=1 when `!fifo_empty`, in PREAMBLE/SFD/PAYLOAD, (buffered + in-flight) < 2, and requested bytes < `len`.
- No read is ever issued past `len` bytes.
- `fifo_empty` during PAYLOAD: `tx_valid` drops once the buffer drains. Output resumes with the next byte; no byte is duplicated or lost.
- `start` while `busy`=1 is ignored. `start` and `len` have no effect outside IDLE.

## Timing
- Reset values: `busy`=0, `fifo_rd_en`=0, `tx_valid`=0, `tx_data`=0x00, `tx_last`=0; state IDLE, buffer empty.
- `start` at cycle t: `busy`=1 and `tx_valid`=1 with `tx_data`=0x55 at t+1.
- `tx_valid` and `tx_data` are registered.
- Handshake rule: once `tx_valid`=1, `tx_valid`, `tx_data` and `tx_last` stay stable until `tx_ready`=1.
- Throughput: 1 byte/cycle with `tx_ready` held high and the FIFO non-empty, including across the SFD→PAYLOAD and PAYLOAD→PAD/FCS boundaries.
- Prefetch begins during PREAMBLE, so the first payload byte follows SFD with no bubble.
- `busy` deasserts on the cycle after the last IFG cycle; a `start` on that cycle is accepted.
- `rst` mid-frame: return to IDLE and take reset values on the next edge. The in-flight FIFO byte is discarded. No `tx_last` is emitted.

## Configuration
- `TX_FCS_EN` defined: FCS state and CRC logic are present; `tx_last` marks the 4th FCS byte.
- `TX_FCS_EN` undefined: no CRC logic. PAD (or PAYLOAD) goes directly to IFG, and `tx_last` marks the final payload/pad byte.

## Test plan
- `MIN_LEN`=9, `TX_FCS_EN`, FIFO loaded with ASCII "123456789", `len`=9, `tx_ready`=1 → 55×7, D5, 31..39, 26 39 F4 CB. `tx_last` is on 0xCB; 21 consecutive valid cycles.
- `MIN_LEN`=60, `len`=1, FIFO holds 0xAB → 8 preamble/SFD bytes, 0xAB, 59×0x00, 4 FCS bytes. That is 72 handshakes total with `tx_last` on the 72nd, then `busy` held 12 more cycles.
- `tx_ready` toggling 1010…, `len`=64 → every byte held stable while `tx_ready`=0, and the byte sequence is identical to the `tx_ready`=1 run.
- FIFO empty after 3 of `len`=10 bytes for 5 cycles, then refilled → `tx_valid` low during the gap, payload resumes at byte 4, and there are exactly 10 FIFO reads.
- `rst` pulsed at the 5th payload byte → next cycle all outputs at reset values. A following `start` with `len`=2 produces a correct fresh frame.
- `start` pulsed during PAYLOAD and during IFG → ignored, with no second frame. `start` on the cycle `busy` falls is accepted.
